// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op-code encodings and default latencies.
// Also used by the ID-stage decoder.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam int MD_CNT_W       = 16;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic for latched operands: returns {hi,lo}.
// Divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_hilo
);

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_sa     = $signed(i_a);
    assign w_sb     = $signed(i_b);
    assign w_a_neg  = w_signed && (w_sa < 0);
    assign w_b_neg  = w_signed && (w_sb < 0);

    // Sign-extending to 64 bits gives the signed product modulo 2^64
    assign w_ext_a = w_a_neg ? {32'hFFFF_FFFF, i_a} : {32'h0, i_a};
    assign w_ext_b = w_b_neg ? {32'hFFFF_FFFF, i_b} : {32'h0, i_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_mag_a   = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_mag_b   = w_b_neg ? (~i_b + 32'd1) : i_b;
    assign w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag   = w_mag_a / w_divisor;
    assign w_r_mag   = w_mag_a % w_divisor;
    assign w_q       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r       = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        o_hilo = 64'd0;
        if (md_is_mul(i_op)) begin
            o_hilo = w_prod;
        end else if (md_is_div(i_op)) begin
            o_hilo = {w_r, w_q};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// IDLE/RUN FSM with a down-counter; results land on the edge busy falls.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state;
    logic [MD_CNT_W-1:0] r_cnt;
    logic [2:0]          r_op;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    state_t              w_state_nxt;
    logic [MD_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]          w_op_nxt;
    logic [31:0]         w_a_nxt;
    logic [31:0]         w_b_nxt;
    logic [31:0]         w_hi_nxt;
    logic [31:0]         w_lo_nxt;
    logic [63:0]         w_hilo;
    logic                w_div0;

    md_calc u_calc (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_hilo (w_hilo)
    );

    assign w_div0 = md_is_div(r_op) && (r_b == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (md_is_mul(op) || md_is_div(op)) begin
                        w_op_nxt    = op;
                        w_a_nxt     = a;
                        w_b_nxt     = b;
                        w_cnt_nxt   = md_is_mul(op) ? MD_CNT_W'(MULT_CYCLES)
                                                    : MD_CNT_W'(DIV_CYCLES);
                        w_state_nxt = RUN;
                    end else if (op == MD_MTHI) begin
                        w_hi_nxt = a;
                    end else if (op == MD_MTLO) begin
                        w_lo_nxt = a;
                    end
                end
            end
            RUN: begin
                w_cnt_nxt = r_cnt - MD_CNT_W'(1);
                // Last busy cycle: commit unless this was a divide by zero
                if (r_cnt <= MD_CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (!w_div0) begin
                        w_hi_nxt = w_hilo[63:32];
                        w_lo_nxt = w_hilo[31:0];
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state == RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request from the EX stage, qualified by op.
REQ-006 SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port a  input  32  first operand (rs value).
REQ-008 SHALL have port b  input  32  second operand (rt value).
REQ-009 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.

Function
REQ-012 SHALL implement FSM states IDLE and RUN, with a down-counter holding the remaining cycles.
REQ-013 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch a, b and op, load the counter, and enter RUN.
REQ-014 For a start sampled at edge N, busy SHALL be high from after edge N through edge N+LAT, where LAT = MULT_CYCLES or DIV_CYCLES.
REQ-015 At edge N+LAT, hi/lo SHALL update and busy SHALL fall in the same cycle, then the FSM returns to IDLE.
REQ-016 hi/lo SHALL hold their previous values throughout RUN.
REQ-017 MULT SHALL form the signed 64-bit product of a and b; MULTU the unsigned product; hi = [63:32], lo = [31:0].
REQ-018 DIV/DIVU SHALL set lo = quotient and hi = remainder (signed or unsigned respectively).
REQ-019 Signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0.
REQ-021 Divide by zero (b = 0) SHALL still run DIV_CYCLES, and hi/lo SHALL keep their prior values.
REQ-022 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at the next edge, with no busy cycle.
REQ-023 start (any op) while busy SHALL be ignored: no state, operand or register change.
REQ-024 start with an undefined op code SHALL be ignored.
REQ-025 Results SHALL use operands latched at start; a/b changes during RUN SHALL have no effect.
REQ-026 Back-to-back: start in the cycle busy is low after completion SHALL be accepted normally.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, busy = 0, hi = 0, lo = 0, and counter = 0, regardless of clk.
REQ-028 Reset during RUN SHALL abandon the operation, with no late hi/lo write after deassertion.
REQ-029 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-030 Op-code encodings and default latency constants SHALL reside in shared package md_pkg, also used by the decoder in the ID stage.
REQ-031 The FSM state type SHALL be local to md_unit.
REQ-032 Arithmetic MAY be computed combinationally from the latched operands at completion; no sub-module is required.
REQ-033 If one is factored out, it SHALL be md_calc: combinational, taking latched op/a/b and producing 64-bit {hi,lo}.
REQ-034 The busy output SHALL be registered, with no combinational path from start to busy.

Verification
REQ-035 MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-038 MTHI a=0x12345678, then DIVU a=5, b=0 -> hi stays 0x12345678 and busy lasts 10 cycles; MTLO start during that busy -> lo unchanged.
REQ-039 MULT 100*100 with reset pulsed at busy cycle 3 -> busy=0, hi=lo=0 immediately and remain 0 for 10 cycles after release.
REQ-040 MULT then DIV issued the cycle after busy falls -> both accepted; final lo/hi match the DIV result with no lost cycles.
